// File: rtl/relm_pkg.sv
// Shared constants and FSM state encoding for the sequential radix-8 divider.
// Optional feature macro: RELM_DIV_SIGNED_EN adds the signed fix-up state.
package relm_pkg;

    localparam int RELM_WD    = 32;   // operand / quotient / remainder width
    localparam int RELM_LOOPS = 10;   // 3-bit loop steps, RELM_WD = 2 + 3*RELM_LOOPS

`ifdef RELM_DIV_SIGNED_EN
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        INIT = 3'd1,
        LOOP = 3'd2,
        DONE = 3'd3,
        FIX  = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        LOOP = 2'd2,
        DONE = 2'd3
    } state_t;
`endif

endpackage

// File: rtl/relm_div_step.sv
// Combinational 3-bit restoring division step.
// Retires three quotient bits from the partial remainder i_r and the next
// three dividend bits. The first two restoring steps are merged into one
// radix-4 digit select against D, 2D and the precomputed 3D; this yields the
// same bits and remainder as two chained compare-subtract steps. The third
// bit is a plain restoring step. All compares are WD+2 bits wide so that
// 4R + 3 and 3D cannot overflow.
module relm_div_step
    import relm_pkg::*;
#(
    parameter int WD = RELM_WD
) (
    input  logic [WD-1:0] i_r,     // partial remainder (R < D, or R <= N when D = 0)
    input  logic [WD-1:0] i_d,     // divisor D
    input  logic [WD+1:0] i_d3,    // 3*D
    input  logic [2:0]    i_bits,  // next three dividend bits, MSB first
    output logic [WD-1:0] o_r,     // updated partial remainder
    output logic [2:0]    o_q      // three quotient bits, MSB first
);

    localparam int AW = WD + 2;

    logic [AW-1:0] w_x;
    logic [AW-1:0] w_d1;
    logic [AW-1:0] w_d2;
    logic [AW-1:0] w_r1;
    logic [AW-1:0] w_y;
    logic [AW-1:0] w_r2;
    logic [1:0]    w_dig;
    logic          w_q0;

    assign w_x  = {i_r, i_bits[2:1]};
    assign w_d1 = {2'b00, i_d};
    assign w_d2 = {1'b0, i_d, 1'b0};

    // Radix-4 digit select: equivalent to two chained restoring steps.
    // NOTE: every output of a combinational block gets a default first so
    // that no path leaves it unassigned and a latch is never inferred.
    always_comb begin
        w_dig = 2'd0;
        w_r1  = w_x;
        if (w_x >= i_d3) begin
            w_dig = 2'd3;
            w_r1  = w_x - i_d3;
        end else if (w_x >= w_d2) begin
            w_dig = 2'd2;
            w_r1  = w_x - w_d2;
        end else if (w_x >= w_d1) begin
            w_dig = 2'd1;
            w_r1  = w_x - w_d1;
        end
    end

    // Third bit: one ordinary restoring step.
    assign w_y  = {w_r1[AW-2:0], i_bits[0]};
    assign w_q0 = (w_y >= w_d1);
    assign w_r2 = w_q0 ? (w_y - w_d1) : w_y;

    assign o_r = w_r2[WD-1:0];
    assign o_q = {w_dig, w_q0};

endmodule

// File: rtl/relm_div_seq.sv
// Sequential restoring divider, 3 quotient bits per clock.
// IDLE -> INIT (2 bits) -> LOOP (LOOPS x 3 bits) -> DONE, held until ack_in.
// Optional feature macro: RELM_DIV_SIGNED_EN enables truncating signed
// division via signed_in, with one extra fix-up cycle before DONE.
module relm_div_seq
    import relm_pkg::*;
#(
    parameter int WD    = RELM_WD,
    parameter int LOOPS = RELM_LOOPS
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start_in,
    output logic          ready_out,
    input  logic [WD-1:0] n_in,
    input  logic [WD-1:0] d_in,
    input  logic          signed_in,
    output logic          valid_out,
    input  logic          ack_in,
    output logic [WD-1:0] q_out,
    output logic [WD-1:0] r_out
);

    localparam int CNT_W = $clog2(LOOPS);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [WD-1:0]    r_a;      // dividend shifts out the top, quotient shifts in the bottom
    logic [WD-1:0]    r_d;
    logic [WD:0]      r_d3h;    // 3D >> 1; bit 0 of 3D equals bit 0 of D
    logic [WD-1:0]    r_rem;
    logic [WD-1:0]    r_q;
    logic [WD-1:0]    r_r;

    logic [WD-1:0]    w_n_op;
    logic [WD-1:0]    w_d_op;
    logic [WD+1:0]    w_d3;
    logic [2:0]       w_bits;
    logic [WD-1:0]    w_step_r;
    logic [2:0]       w_step_q;
    logic             w_last;

`ifdef RELM_DIV_SIGNED_EN
    logic r_sop;
    logic r_neg_q;
    logic r_neg_r;

    // Signed requests divide magnitudes; signs are restored in FIX.
    assign w_n_op = (signed_in && n_in[WD-1]) ? -n_in : n_in;
    assign w_d_op = (signed_in && d_in[WD-1]) ? -d_in : d_in;
`else
    assign w_n_op = n_in;
    assign w_d_op = d_in;
`endif

    assign w_d3   = {2'b00, w_d_op} + {1'b0, w_d_op, 1'b0};
    assign w_last = (r_cnt == CNT_W'(LOOPS - 1));

    // INIT retires only two bits: the top step input is forced to zero.
    assign w_bits = (r_state == INIT) ? {1'b0, r_a[WD-1:WD-2]} : r_a[WD-1:WD-3];

    relm_div_step #(.WD(WD)) u_step (
        .i_r    (r_rem),
        .i_d    (r_d),
        .i_d3   ({r_d3h, r_d[0]}),
        .i_bits (w_bits),
        .o_r    (w_step_r),
        .o_q    (w_step_q)
    );

    // State register.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        ready_out   = 1'b0;
        valid_out   = 1'b0;
        unique case (r_state)
            IDLE: begin
                ready_out = 1'b1;
                if (start_in) begin
                    w_state_nxt = INIT;
                end
            end
            INIT: begin
                w_state_nxt = LOOP;
            end
            LOOP: begin
                if (w_last) begin
`ifdef RELM_DIV_SIGNED_EN
                    w_state_nxt = r_sop ? FIX : DONE;
`else
                    w_state_nxt = DONE;
`endif
                end
            end
            DONE: begin
                valid_out = 1'b1;
                if (ack_in) begin
                    w_state_nxt = IDLE;
                end
            end
`ifdef RELM_DIV_SIGNED_EN
            FIX: begin
                w_state_nxt = DONE;
            end
`endif
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: operand capture, per-step shift/remainder update, result load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_a     <= '0;
            r_d     <= '0;
            r_d3h   <= '0;
            r_rem   <= '0;
            r_q     <= '0;
            r_r     <= '0;
`ifdef RELM_DIV_SIGNED_EN
            r_sop   <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (start_in) begin
                        r_a   <= w_n_op;
                        r_d   <= w_d_op;
                        r_d3h <= w_d3[WD+1:1];
                        r_rem <= '0;
                        r_cnt <= '0;
`ifdef RELM_DIV_SIGNED_EN
                        r_sop   <= signed_in;
                        r_neg_q <= signed_in && (n_in[WD-1] != d_in[WD-1]);
                        r_neg_r <= signed_in && n_in[WD-1];
`endif
                    end
                end
                INIT: begin
                    r_a   <= {r_a[WD-3:0], w_step_q[1:0]};
                    r_rem <= w_step_r;
                    r_cnt <= '0;
                end
                LOOP: begin
                    r_a   <= {r_a[WD-4:0], w_step_q};
                    r_rem <= w_step_r;
                    r_cnt <= r_cnt + 1'b1;
`ifdef RELM_DIV_SIGNED_EN
                    if (w_last && !r_sop) begin
`else
                    if (w_last) begin
`endif
                        r_q <= {r_a[WD-4:0], w_step_q};
                        r_r <= w_step_r;
                    end
                end
`ifdef RELM_DIV_SIGNED_EN
                FIX: begin
                    r_q <= r_neg_q ? -r_a : r_a;
                    r_r <= r_neg_r ? -r_rem : r_rem;
                end
`endif
                default: begin
                end
            endcase
        end
    end

    assign q_out = r_q;
    assign r_out = r_r;

endmodule

// File: tb/tb_relm_div_seq.sv
// Self-checking bench for relm_div_seq: directed operations with a result
// scoreboard, handshake hold, busy start pulses, and reset mid-operation.
module tb_relm_div_seq;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        start_in;
    logic        ready_out;
    logic [31:0] n_in;
    logic [31:0] d_in;
    logic        signed_in;
    logic        valid_out;
    logic        ack_in;
    logic [31:0] q_out;
    logic [31:0] r_out;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];

    relm_div_seq dut (
        .clk       (clk),
        .reset     (reset),
        .start_in  (start_in),
        .ready_out (ready_out),
        .n_in      (n_in),
        .d_in      (d_in),
        .signed_in (signed_in),
        .valid_out (valid_out),
        .ack_in    (ack_in),
        .q_out     (q_out),
        .r_out     (r_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Unsigned reference: D = 0 gives all-ones quotient and remainder N.
    function automatic exp_t model_u(input logic [31:0] n, input logic [31:0] d);
        exp_t e;
        if (d == 32'd0) begin
            e.q = 32'hFFFF_FFFF;
            e.r = n;
        end else begin
            e.q = n / d;
            e.r = n % d;
        end
        return e;
    endfunction

    // One full transaction: accept, latency, results, hold, ack.
    task automatic run_op(input logic [31:0] n, input logic [31:0] d, input logic sgn,
                          input logic [31:0] eq, input logic [31:0] er,
                          input int hold, input string tag);
        exp_t item;
        int   e;
        int   lat;
        lat = 11;
`ifdef RELM_DIV_SIGNED_EN
        if (sgn) lat = 12;
`endif
        @(negedge clk);
        check({tag, ":ready"}, {31'b0, ready_out}, 32'd1);
        n_in      = n;
        d_in      = d;
        signed_in = sgn;
        start_in  = 1'b1;
        sb.push_back('{q: eq, r: er});
        @(negedge clk);
        start_in = 1'b0;
        n_in     = ~n;
        d_in     = 32'd5;
        e = 0;
        while (!valid_out && e < 40) begin
            start_in = (e == 4);
            @(negedge clk);
            e++;
        end
        start_in = 1'b0;
        check({tag, ":latency"}, 32'(e), 32'(lat));
        item = sb.pop_front();
        check({tag, ":q"}, q_out, item.q);
        check({tag, ":r"}, r_out, item.r);
        for (int h = 0; h < hold; h++) begin
            start_in = h[0];
            @(negedge clk);
            check({tag, ":hold_valid"}, {31'b0, valid_out}, 32'd1);
            check({tag, ":hold_q"}, q_out, item.q);
            check({tag, ":hold_r"}, r_out, item.r);
        end
        start_in = 1'b0;
        ack_in   = 1'b1;
        @(negedge clk);
        ack_in = 1'b0;
        check({tag, ":idle_ready"}, {31'b0, ready_out}, 32'd1);
        check({tag, ":idle_valid"}, {31'b0, valid_out}, 32'd0);
        check({tag, ":idle_q_held"}, q_out, item.q);
    endtask

    initial begin
        exp_t        m;
        logic [31:0] rn;
        logic [31:0] rd;

        reset     = 1'b1;
        start_in  = 1'b0;
        n_in      = '0;
        d_in      = '0;
        signed_in = 1'b0;
        ack_in    = 1'b0;
        repeat (2) @(negedge clk);
        check("rst:ready", {31'b0, ready_out}, 32'd1);
        check("rst:valid", {31'b0, valid_out}, 32'd0);
        check("rst:q", q_out, 32'd0);
        check("rst:r", r_out, 32'd0);
        reset = 1'b0;

        // Basic case with a 5-cycle consumer stall and busy start pulses.
        run_op(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 5, "n100_d7");
        run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 0, "max_d1");
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd1, 32'd0, 0, "max_dmax");
        run_op(32'h0000_1234, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h0000_1234, 1, "div_zero");
        run_op(32'd0, 32'd5, 1'b0, 32'd0, 32'd0, 0, "zero_n");
        run_op(32'd5, 32'd9, 1'b0, 32'd0, 32'd5, 0, "n_lt_d");
        run_op(32'h8000_0000, 32'd3, 1'b0, 32'h2AAA_AAAA, 32'd2, 0, "msb_d3");
        run_op(32'hDEAD_BEEF, 32'h8000_0001, 1'b0, 32'd1, 32'h5EAD_BEEE, 0, "big_d");

        for (int k = 0; k < 6; k++) begin
            rn = $urandom;
            rd = (k < 3) ? ($urandom >> $urandom_range(0, 30)) : $urandom_range(1, 1000);
            m  = model_u(rn, rd);
            run_op(rn, rd, 1'b0, m.q, m.r, 0, "rand");
        end

        // Reset asserted mid-LOOP: in-flight work discarded immediately.
        @(negedge clk);
        n_in     = 32'd999;
        d_in     = 32'd4;
        start_in = 1'b1;
        @(negedge clk);
        start_in = 1'b0;
        repeat (5) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check("midrst:ready", {31'b0, ready_out}, 32'd1);
        check("midrst:valid", {31'b0, valid_out}, 32'd0);
        check("midrst:q", q_out, 32'd0);
        check("midrst:r", r_out, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst:no_accept", {31'b0, ready_out}, 32'd1);
        run_op(32'd1000, 32'd33, 1'b0, 32'd30, 32'd10, 0, "after_rst");

`ifdef RELM_DIV_SIGNED_EN
        run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0, "s_m7_2");
        run_op(32'hFFFF_FFF9, 32'd2, 1'b0, 32'h7FFF_FFFC, 32'd1, 0, "u_m7_2");
        run_op(32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 0, "s_7_m2");
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/relm_div_seq.md
RELM_DIV_SEQ -- requirements
Module: relm_div_seq

Interface
REQ-001 SHALL have parameter WD, default 32: operand, quotient and remainder width; legal values are 32 only.
REQ-002 SHALL have parameter LOOPS, default 10: number of 3-bit loop steps; WD = 2 + 3*LOOPS.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port start_in, input, 1 bit: request to divide.
REQ-006 SHALL have port ready_out, output, 1 bit: high when a request can be accepted.
REQ-007 SHALL have port n_in, input, WD bits: dividend N.
REQ-008 SHALL have port d_in, input, WD bits: divisor D.
REQ-009 SHALL have port signed_in, input, 1 bit: signed operation request; ignored when RELM_DIV_SIGNED_EN is undefined.
REQ-010 SHALL have port valid_out, output, 1 bit: quotient and remainder are valid.
REQ-011 SHALL have port ack_in, input, 1 bit: consumer accepts the result.
REQ-012 SHALL have port q_out, output, WD bits: quotient.
REQ-013 SHALL have port r_out, output, WD bits: remainder.

Function
REQ-014 SHALL implement the FSM states IDLE, INIT, LOOP and DONE; ready_out = (state == IDLE); valid_out = (state == DONE).
REQ-015 SHALL, in IDLE, accept a request on a clock edge where start_in = 1: register N into the shift register A, register D and 3D>>1, clear R, and go to INIT.
REQ-016 SHALL, in INIT (one cycle), retire the 2 most-significant quotient bits, go to LOOP, and clear the step counter.
REQ-017 SHALL, in LOOP, retire 3 quotient bits per cycle using restoring compare-subtract (three chained steps against D, each computing R' = 2R + next N bit, subtracting D when R' >= D), and increment the counter.
REQ-018 SHALL go from LOOP to DONE on the edge where the counter equals LOOPS-1.
REQ-019 SHALL make valid_out rise exactly 1+LOOPS = 11 rising edges after the accepting edge.
REQ-020 SHALL hold q_out and r_out stable in DONE until ack_in = 1, then return to IDLE on that edge; ack_in is ignored outside DONE.
REQ-021 SHALL ignore start_in while not in IDLE; no queueing.
REQ-022 SHALL perform all comparisons at WD+2 bits so that 2R + 1 and 3D never overflow.
REQ-023 SHALL, for D = 0, produce q_out = all ones and r_out = N; no exception signal.
REQ-024 SHALL hold q_out and r_out at their last value outside DONE; they are meaningful only while valid_out = 1.

Reset
REQ-025 SHALL, on reset assertion at any time (including mid-operation), immediately force state = IDLE, counter = 0, q_out = 0, r_out = 0, ready_out = 1 and valid_out = 0; any in-flight division is discarded.
REQ-026 SHALL not accept a request on the first edge after reset deasserts unless start_in = 1 at that edge.

Configuration
REQ-027 SHALL, when RELM_DIV_SIGNED_EN is defined and signed_in = 1 at accept, divide magnitudes, then negate the quotient if sign(N) != sign(D) and give the remainder the sign of N (truncating division); the result appears one extra cycle later (a fix-up cycle in DONE entry, so valid_out rises at edge 12).
REQ-028 SHALL, when RELM_DIV_SIGNED_EN is undefined, perform unsigned division only, with no added logic or latency.

Structure
REQ-029 SHALL take state encodings (IDLE/INIT/LOOP/DONE) and the WD/LOOPS constants from the shared package relm_pkg.
REQ-030 SHALL place the combinational 3-bit restoring step (inputs R, D, 3 N bits; outputs R', 3 quotient bits) in the sub-module relm_div_step; INIT reuses it with the top bit forced to 0.

Verification
REQ-031 SHALL verify: N = 100, D = 7 -> q = 14, r = 2, with valid_out rising 11 edges after accept.
REQ-032 SHALL verify: N = 0xFFFFFFFF, D = 1 -> q = 0xFFFFFFFF, r = 0; and N = 0xFFFFFFFF, D = 0xFFFFFFFF -> q = 1, r = 0.
REQ-033 SHALL verify: D = 0, N = 0x1234 -> q = 0xFFFFFFFF, r = 0x1234.
REQ-034 SHALL verify: ack_in held low 5 cycles -> valid_out, q_out and r_out stay stable; start_in pulses during busy and hold are ignored.
REQ-035 SHALL verify: reset asserted in LOOP cycle 4 -> ready_out = 1 and valid_out = 0 immediately; the next request computes correctly.
REQ-036 SHALL verify, with RELM_DIV_SIGNED_EN: -7 / 2 signed -> q = 0xFFFFFFFD, r = 0xFFFFFFFF; the same operands unsigned -> q = 0x7FFFFFFC, r = 1.
